// File: rtl/rx_frame_sync_if.sv
// Serial-in / parallel-out bundle between the clock-recovery stage and the frame aligner.
// The master side drives the recovered bit stream, and the slave side returns aligned words.
interface rx_frame_sync_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  clkStrobe;
  logic                  rxClocked;
  logic [WORD_WIDTH-1:0] dataOut;
  logic                  dataValid;
  logic                  frameStart;
  logic                  locked;
  logic                  syncErr;

  modport master (
    output clkStrobe, rxClocked,
    input  dataOut, dataValid, frameStart, locked, syncErr
  );

  modport slave (
    input  clkStrobe, rxClocked,
    output dataOut, dataValid, frameStart, locked, syncErr
  );
endinterface

// File: rtl/rx_frame_sync.sv
// Frame aligner and deserializer: hunts for the sync word, confirms alignment over several frames,
// then emits data words with frame markers until repeated sync-slot misses force a new hunt.
module rx_frame_sync #(
  parameter int                    WORD_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] SYNC_WORD   = 8'hD5,
  parameter int                    FRAME_WORDS = 4,
  parameter int                    LOCK_COUNT  = 2,
  parameter int                    LOSS_COUNT  = 3
) (
  input logic           clk,
  input logic           rst,
  rx_frame_sync_if.slave bus
);

  localparam int BSW = $clog2(WORD_WIDTH + 1);
  localparam int BCW = $clog2(WORD_WIDTH);
  localparam int WCW = $clog2(FRAME_WORDS + 1);
  localparam int CCW = $clog2(LOCK_COUNT + 1);
  localparam int MCW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } stateT;

  stateT                 state, stateNext;
  logic [WORD_WIDTH-1:0] sr, srNext;
  logic [BSW-1:0]        bitsSeen, bitsSeenNext;
  logic [BCW-1:0]        bitCnt, bitCntNext;
  logic [WCW-1:0]        wordCnt, wordCntNext;
  logic [CCW-1:0]        confirmCnt, confirmCntNext;
  logic [MCW-1:0]        missCnt, missCntNext;
  logic [WORD_WIDTH-1:0] dataOutR, dataOutNext;
  logic                  dataValidR, dataValidNext;
  logic                  frameStartR, frameStartNext;
  logic                  lockedR, lockedNext;
  logic                  syncErrR, syncErrNext;
  logic                  syncMatch;

  // State and datapath registers; rst wins over any strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      sr          <= '0;
      bitsSeen    <= '0;
      bitCnt      <= '0;
      wordCnt     <= '0;
      confirmCnt  <= '0;
      missCnt     <= '0;
      dataOutR    <= '0;
      dataValidR  <= 1'b0;
      frameStartR <= 1'b0;
      lockedR     <= 1'b0;
      syncErrR    <= 1'b0;
    end else begin
      state       <= stateNext;
      sr          <= srNext;
      bitsSeen    <= bitsSeenNext;
      bitCnt      <= bitCntNext;
      wordCnt     <= wordCntNext;
      confirmCnt  <= confirmCntNext;
      missCnt     <= missCntNext;
      dataOutR    <= dataOutNext;
      dataValidR  <= dataValidNext;
      frameStartR <= frameStartNext;
      lockedR     <= lockedNext;
      syncErrR    <= syncErrNext;
    end
  end

  // Next-state, counter and output decode; only a strobe advances anything but the pulses.
  always_comb begin
    stateNext      = state;
    srNext         = sr;
    bitsSeenNext   = bitsSeen;
    bitCntNext     = bitCnt;
    wordCntNext    = wordCnt;
    confirmCntNext = confirmCnt;
    missCntNext    = missCnt;
    dataOutNext    = dataOutR;
    dataValidNext  = 1'b0;
    frameStartNext = 1'b0;
    syncErrNext    = 1'b0;
    syncMatch      = 1'b0;

    if (bus.clkStrobe) begin
      srNext    = (sr << 1) | WORD_WIDTH'(bus.rxClocked);
      syncMatch = (srNext == SYNC_WORD);
      if (bitsSeen != BSW'(WORD_WIDTH)) begin
        bitsSeenNext = bitsSeen + BSW'(1);
      end else begin
        bitsSeenNext = bitsSeen;
      end

      case (state)
        HUNT: begin
          // bitsSeen keeps a zero sync word from matching the cleared shift register.
          if ((bitsSeenNext == BSW'(WORD_WIDTH)) && syncMatch) begin
            stateNext      = VERIFY;
            bitCntNext     = BCW'(0);
            wordCntNext    = WCW'(0);
            confirmCntNext = CCW'(0);
          end else begin
            stateNext = HUNT;
          end
        end
        VERIFY, LOCKED: begin
          if (bitCnt == BCW'(WORD_WIDTH - 1)) begin
            bitCntNext = BCW'(0);
            if (wordCnt == WCW'(FRAME_WORDS)) begin
              wordCntNext = WCW'(0);
              if (state == VERIFY) begin
                if (syncMatch) begin
                  confirmCntNext = confirmCnt + CCW'(1);
                  if (confirmCntNext == CCW'(LOCK_COUNT)) begin
                    stateNext   = LOCKED;
                    missCntNext = MCW'(0);
                  end else begin
                    stateNext = VERIFY;
                  end
                end else begin
                  syncErrNext = 1'b1;
                  stateNext   = HUNT;
                end
              end else begin
                // Tolerated misses keep frame timing; only LOSS_COUNT in a row drop lock.
                if (syncMatch) begin
                  missCntNext = MCW'(0);
                end else begin
                  syncErrNext = 1'b1;
                  missCntNext = missCnt + MCW'(1);
                  if (missCntNext == MCW'(LOSS_COUNT)) begin
                    stateNext = HUNT;
                  end else begin
                    stateNext = LOCKED;
                  end
                end
              end
            end else begin
              wordCntNext = wordCnt + WCW'(1);
              if (state == LOCKED) begin
                dataOutNext    = srNext;
                dataValidNext  = 1'b1;
                frameStartNext = (wordCnt == WCW'(0));
              end else begin
                dataOutNext = dataOutR;
              end
            end
          end else begin
            bitCntNext = bitCnt + BCW'(1);
          end
        end
        default: begin
          stateNext = HUNT;
        end
      endcase
    end else begin
      srNext = sr;
    end

    lockedNext = (stateNext == LOCKED);
  end

  assign bus.dataOut    = dataOutR;
  assign bus.dataValid  = dataValidR;
  assign bus.frameStart = frameStartR;
  assign bus.locked     = lockedR;
  assign bus.syncErr    = syncErrR;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Directed bench for rx_frame_sync: a table of transmitted words with the outputs expected
// one cycle after each word's last-bit strobe, plus reset and back-to-back strobe sequences.
module tb_rx_frame_sync;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_frame_sync_if #(.WORD_WIDTH(8)) bus ();

  rx_frame_sync dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] word;
    logic       dv;
    logic       fs;
    logic       lk;
    logic       se;
    logic [7:0] data;
  } vecT;

  vecT vecs[$];
  int  checks = 0;
  int  errors = 0;
  int  dvCnt  = 0;
  int  seCnt  = 0;

  // Pulse counters, sampled mid-cycle so each one-cycle pulse is seen exactly once.
  always @(negedge clk) begin
    if (bus.dataValid === 1'b1) dvCnt++;
    if (bus.syncErr === 1'b1) seCnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic addV(input logic [7:0] w, input logic dv, input logic fs, input logic lk,
                      input logic se, input logic [7:0] d);
    vecT v;
    v.word = w; v.dv = dv; v.fs = fs; v.lk = lk; v.se = se; v.data = d;
    vecs.push_back(v);
  endtask

  // Data words 11 22 33 44: emitted when locked, otherwise dataOut keeps 'held'.
  task automatic addStd(input logic emit, input logic lk, input logic [7:0] held);
    logic [7:0] w;
    for (int k = 0; k < 4; k++) begin
      w = 8'h11 * 8'(k + 1);
      addV(w, emit, emit && (k == 0), lk, 1'b0, emit ? w : held);
    end
  endtask

  // One bit with its strobe; gap is the strobe period in cycles (1 = back-to-back).
  task automatic sendBit(input logic b, input int gap, input bit sample, output logic [11:0] obs);
    @(negedge clk);
    bus.clkStrobe = 1'b1;
    bus.rxClocked = b;
    obs = 12'h000;
    if (sample) begin
      @(posedge clk);
      #1;
      obs = {bus.dataValid, bus.frameStart, bus.locked, bus.syncErr, bus.dataOut};
    end
    if (gap > 1) begin
      @(negedge clk);
      bus.clkStrobe = 1'b0;
      repeat (gap - 2) @(negedge clk);
    end
  endtask

  task automatic sendPrefix(input int gap);
    logic [4:0]  p;
    logic [11:0] obs;
    p = 5'b00110;
    for (int b = 4; b >= 0; b--) sendBit(p[b], gap, 1'b0, obs);
  endtask

  task automatic runVecs(input int first, input int last, input int gap, input string tag);
    logic [11:0] obs;
    logic [7:0]  w;
    for (int i = first; i <= last; i++) begin
      w = vecs[i].word;
      for (int b = 7; b >= 0; b--) sendBit(w[b], gap, (b == 0), obs);
      check($sformatf("%s_vec%0d_%h", tag, i, w), {20'h0, obs},
            {20'h0, vecs[i].dv, vecs[i].fs, vecs[i].lk, vecs[i].se, vecs[i].data});
    end
    @(negedge clk);
    bus.clkStrobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    check(name, {20'h0, bus.dataValid, bus.frameStart, bus.locked, bus.syncErr, bus.dataOut}, 32'h0);
  endtask

  initial begin
    int d0;
    int s0;
    logic [11:0] obs;

    // Acquisition: three sync words, then the first locked frame.
    addV(8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    addStd(1'b0, 1'b0, 8'h00);
    addV(8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    addStd(1'b0, 1'b0, 8'h00);
    addV(8'hD5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    addStd(1'b1, 1'b1, 8'h00);
    // Sync pattern inside data is plain data.
    addV(8'hD5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44);
    for (int k = 0; k < 4; k++) addV(8'hD5, 1'b1, (k == 0), 1'b1, 1'b0, 8'hD5);
    // Two misses, a good sync clears the count, then three misses drop lock.
    addV(8'hD4, 1'b0, 1'b0, 1'b1, 1'b1, 8'hD5);
    addStd(1'b1, 1'b1, 8'h00);
    addV(8'hD4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44);
    addStd(1'b1, 1'b1, 8'h00);
    addV(8'hD5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44);
    addStd(1'b1, 1'b1, 8'h00);
    addV(8'hD4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44);
    addStd(1'b1, 1'b1, 8'h00);
    addV(8'hD4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44);
    addStd(1'b1, 1'b1, 8'h00);
    addV(8'hD4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44);
    addStd(1'b0, 1'b0, 8'h44);
    // Re-hunt, then a failed sync slot during verification.
    addV(8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44);
    addStd(1'b0, 1'b0, 8'h44);
    addV(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44);
    addV(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44);
    addV(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44);

    // Reset held while bits are strobed.
    rst = 1'b1;
    bus.clkStrobe = 1'b0;
    bus.rxClocked = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.clkStrobe = c[0];
      bus.rxClocked = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    checkAllZero("reset_outputs");

    // 20 quiet cycles of zero bits after release.
    @(negedge clk);
    rst = 1'b0;
    bus.clkStrobe = 1'b0;
    d0 = dvCnt;
    for (int c = 0; c < 5; c++) sendBit(1'b0, 4, 1'b0, obs);
    check("post_reset_no_valid", dvCnt - d0, 32'd0);
    checkAllZero("post_reset_outputs");

    // Full table at one strobe every four cycles.
    sendPrefix(4);
    d0 = dvCnt;
    s0 = seCnt;
    runVecs(0, vecs.size() - 1, 4, "slow");
    check("slow_valid_pulses", dvCnt - d0, 32'd28);
    check("slow_syncerr_pulses", seCnt - s0, 32'd6);

    // Acquisition again with a strobe every cycle.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sendPrefix(1);
    d0 = dvCnt;
    s0 = seCnt;
    runVecs(0, 14, 1, "b2b");
    check("b2b_valid_pulses", dvCnt - d0, 32'd4);
    check("b2b_syncerr_pulses", seCnt - s0, 32'd0);
    check("b2b_still_locked", {31'h0, bus.locked}, 32'd1);

    // Reset mid-word while locked and strobing: outputs clear the next cycle.
    for (int b = 0; b < 3; b++) sendBit(1'b1, 1, 1'b0, obs);
    @(negedge clk);
    rst = 1'b1;
    bus.clkStrobe = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("midframe_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.clkStrobe = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
